// File: rtl/pkt_stream_tx.sv
// rtl/pkt_stream_tx.sv - packet word FIFO feeding a framed valid/ready stream with CRC-8 on the last beat
module pkt_stream_tx #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_keep,
    input  logic        in_last,
    input  logic [1:0]  in_dest,
    input  logic [1:0]  in_src,
    output logic        s_valid,
    input  logic        s_ready,
    output logic        s_sop,
    output logic        s_eop,
    output logic [31:0] s_data,
    output logic [3:0]  s_keep,
    output logic [1:0]  s_dest,
    output logic [1:0]  s_src,
    output logic [7:0]  s_crc,
    output logic        err_keep,
    output logic [15:0] pkt_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [0:0] IN_FIRST = 1'b0;
    localparam logic [0:0] IN_BODY  = 1'b1;
    localparam logic [0:0] OUT_SOP  = 1'b0;
    localparam logic [0:0] OUT_BODY = 1'b1;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    // Entry layout: {first, last, dest, src, keep, data}
    logic [41:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic [0:0]    in_state_q, out_state_q;
    logic [1:0]    dest_q, src_q;
    logic [7:0]    crc_acc_q;
    logic [15:0]   pkt_cnt_q;
    logic          err_keep_q;

    logic        push, pop, keep_ok;
    logic [1:0]  wr_dest, wr_src;
    logic [41:0] head;
    logic [7:0]  crc_beat;

    assign in_ready = !rst && (cnt_q != FULL_CNT);
    assign s_valid  = (cnt_q != '0);
    assign push     = in_valid && in_ready;
    assign pop      = s_valid && s_ready;
    assign head     = mem_q[rd_ptr_q];

    assign keep_ok = in_last ? (in_keep == 4'hF || in_keep == 4'hE || in_keep == 4'hC || in_keep == 4'h8)
                             : (in_keep == 4'hF);

    // Header comes straight from the pins on a packet's first word, from the latch afterwards.
    assign wr_dest = (in_state_q == IN_FIRST) ? in_dest : dest_q;
    assign wr_src  = (in_state_q == IN_FIRST) ? in_src  : src_q;

    always_comb begin
        crc_beat = crc_acc_q;
        for (int i = 0; i < 4; i++) begin
            if (head[35-i]) begin
                crc_beat = crc8_byte(crc_beat, head[31-8*i -: 8]);
            end
        end
    end

    assign s_sop    = s_valid & head[41];
    assign s_eop    = s_valid & head[40];
    assign s_dest   = s_valid ? head[39:38] : 2'b00;
    assign s_src    = s_valid ? head[37:36] : 2'b00;
    assign s_keep   = s_valid ? head[35:32] : 4'h0;
    assign s_data   = s_valid ? head[31:0]  : 32'h0;
    assign s_crc    = s_eop ? crc_beat : 8'h00;
    assign err_keep = err_keep_q;
    assign pkt_cnt  = pkt_cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {(in_state_q == IN_FIRST), in_last, wr_dest, wr_src, in_keep, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            in_state_q  <= IN_FIRST;
            out_state_q <= OUT_SOP;
            dest_q      <= 2'b00;
            src_q       <= 2'b00;
            crc_acc_q   <= 8'h00;
            pkt_cnt_q   <= 16'h0;
            err_keep_q  <= 1'b0;
        end else begin
            err_keep_q <= push && !keep_ok;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (in_state_q == IN_FIRST) begin
                    dest_q <= in_dest;
                    src_q  <= in_src;
                end
                in_state_q <= in_last ? IN_FIRST : IN_BODY;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                if (head[40]) begin
                    out_state_q <= OUT_SOP;
                    crc_acc_q   <= 8'h00;
                    pkt_cnt_q   <= pkt_cnt_q + 16'h1;
                end else begin
                    out_state_q <= OUT_BODY;
                    crc_acc_q   <= crc_beat;
                end
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    a_sop_matches_state: assert property (@(posedge clk) disable iff (rst)
        s_valid |-> (head[41] == (out_state_q == OUT_SOP)));

endmodule
